// File: rtl/ssad_pkg.sv
// Shared types and width helpers for the signed SAD accumulator slice.
package ssad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } ssad_state_e;

  function automatic int ssad_clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sabs_unit.sv
// Combinational signed absolute value; magnitude is exact for the most negative input.
module sabs_unit #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] diff_i,
  output logic [DATAWIDTH-1:0] mag_o,
  output logic                 neg_o
);

  assign neg_o = diff_i[DATAWIDTH-1];
  // Unsigned negate: -(-2^(N-1)) lands on 2^(N-1), which fits N unsigned bits.
  assign mag_o = neg_o ? (~diff_i + 1'b1) : diff_i;

endmodule

// File: rtl/ssad_accum.sv
// Block SAD accumulator: sums |diff| and counts negatives over COUNT samples, result
// held on a valid/ready output; input stalls (in_ready=0) while a result is pending.
module ssad_accum
  import ssad_pkg::*;
#(
  parameter  int DATAWIDTH = 8,
  parameter  int COUNT     = 16,
  localparam int CNTWIDTH  = ssad_clog2(COUNT + 1),
  localparam int SUMWIDTH  = DATAWIDTH + CNTWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 flush,
  input  logic [DATAWIDTH-1:0] diff_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [SUMWIDTH-1:0]  sad_out,
  output logic [CNTWIDTH-1:0]  neg_count,
  output logic                 out_valid,
  input  logic                 out_ready
);

  ssad_state_e         state_q, state_d;
  logic [SUMWIDTH-1:0] acc_q, acc_d;
  logic [CNTWIDTH-1:0] cnt_q, cnt_d;
  logic [CNTWIDTH-1:0] negc_q, negc_d;
  logic [SUMWIDTH-1:0] sad_q, sad_d;
  logic [CNTWIDTH-1:0] nc_q, nc_d;
  logic                ov_q, ov_d;

  logic [DATAWIDTH-1:0] mag;
  logic                 neg;
  logic [SUMWIDTH-1:0]  mag_ext;
  logic [SUMWIDTH-1:0]  acc_sum;
  logic [CNTWIDTH-1:0]  negc_sum;
  logic                 accept;

  sabs_unit #(.DATAWIDTH(DATAWIDTH)) u_abs (
    .diff_i (diff_in),
    .mag_o  (mag),
    .neg_o  (neg)
  );

  assign mag_ext  = SUMWIDTH'(mag);
  assign acc_sum  = acc_q + mag_ext;
  assign negc_sum = negc_q + CNTWIDTH'(neg);
  assign in_ready = (state_q != DONE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    negc_d  = negc_q;
    sad_d   = sad_q;
    nc_d    = nc_q;
    ov_d    = ov_q;
    // flush beats every other event, including a same-cycle sample or emit.
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      negc_d  = '0;
      ov_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d  = mag_ext;
            negc_d = CNTWIDTH'(neg);
            cnt_d  = CNTWIDTH'(1);
            if (COUNT == 1) begin
              sad_d   = mag_ext;
              nc_d    = CNTWIDTH'(neg);
              ov_d    = 1'b1;
              state_d = DONE;
            end else begin
              state_d = ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc_d  = acc_sum;
            negc_d = negc_sum;
            cnt_d  = cnt_q + CNTWIDTH'(1);
            if (cnt_q == CNTWIDTH'(COUNT - 1)) begin
              sad_d   = acc_sum;
              nc_d    = negc_sum;
              ov_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            ov_d    = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            negc_d  = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      negc_q  <= '0;
      sad_q   <= '0;
      nc_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      negc_q  <= negc_d;
      sad_q   <= sad_d;
      nc_q    <= nc_d;
      ov_q    <= ov_d;
    end
  end

  assign sad_out   = sad_q;
  assign neg_count = nc_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_ssad_accum.sv
// Scoreboard bench for ssad_accum (COUNT=4 main instance, COUNT=1 corner instance).
module tb_ssad_accum;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  diff_in;
  logic [10:0] sad_out;
  logic [2:0]  neg_count;

  logic        f1, v1, rdy1, ov1, r1;
  logic [7:0]  d1;
  logic [8:0]  sad1;
  logic [0:0]  neg1;

  ssad_accum #(.DATAWIDTH(8), .COUNT(4)) dut (
    .Clk(Clk), .Rst(Rst), .flush(flush), .diff_in(diff_in), .in_valid(in_valid),
    .in_ready(in_ready), .sad_out(sad_out), .neg_count(neg_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  ssad_accum #(.DATAWIDTH(8), .COUNT(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .flush(f1), .diff_in(d1), .in_valid(v1),
    .in_ready(rdy1), .sad_out(sad1), .neg_count(neg1),
    .out_valid(ov1), .out_ready(r1)
  );

  typedef struct {int sad; int neg;} res_t;
  res_t exp_q[$];
  int   blk[$];
  bit   pending = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   last_sad = -1;
  int   last_neg = -1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a block is simply the list of accepted samples.
  always @(posedge Clk) begin
    if (Rst) begin
      blk.delete();
      exp_q.delete();
      pending = 1'b0;
    end else if (flush) begin
      blk.delete();
      if (pending) exp_q.delete();
      pending = 1'b0;
    end else if (pending) begin
      if (out_ready) pending = 1'b0;
    end else if (in_valid) begin
      blk.push_back(int'($signed(diff_in)));
      if (blk.size() == 4) begin
        res_t r;
        r.sad = 0;
        r.neg = 0;
        foreach (blk[k]) begin
          r.sad += (blk[k] < 0) ? -blk[k] : blk[k];
          if (blk[k] < 0) r.neg++;
        end
        exp_q.push_back(r);
        blk.delete();
        pending = 1'b1;
      end
    end
  end

  always @(negedge Clk) begin
    if (!Rst) begin
      chk("in_ready", int'(in_ready), int'(!pending));
      chk("out_valid", int'(out_valid), int'(pending));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("result_expected", 0, 1);
        end else begin
          chk("sad_out", int'(sad_out), exp_q[0].sad);
          chk("neg_count", int'(neg_count), exp_q[0].neg);
          if (out_ready && !flush) begin
            last_sad = int'(sad_out);
            last_neg = int'(neg_count);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic drive(input int v, input int d, input int r, input int f);
    in_valid  = (v != 0);
    diff_in   = d[7:0];
    out_ready = (r != 0);
    flush     = (f != 0);
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int d, input int r);
    int n;
    n = 0;
    in_valid  = 1'b1;
    diff_in   = d[7:0];
    out_ready = (r != 0);
    flush     = 1'b0;
    while (!in_ready && n < 50) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (n >= 50) chk("send_stall", n, 0);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic reset_mid_cycle();
    #2 Rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sad_out", int'(sad_out), 0);
    chk("rst_neg_count", int'(neg_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst1_out_valid", int'(ov1), 0);
    chk("rst1_sad_out", int'(sad1), 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  function automatic int rand_diff();
    int s;
    s = int'($urandom_range(0, 9));
    if (s == 0) return -128;
    if (s == 1) return 127;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    flush = 0; in_valid = 0; diff_in = 0; out_ready = 0;
    f1 = 0; v1 = 0; d1 = 0; r1 = 0;
    #1 Rst = 1'b1;
    #2;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_sad_out", int'(sad_out), 0);
    chk("init_neg_count", int'(neg_count), 0);
    chk("init_in_ready", int'(in_ready), 1);
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst = 1'b0;

    send(5, 1); send(-3, 1); send(-128, 1); send(0, 1);
    drive(0, 0, 1, 0);
    chk("t1_sad", last_sad, 136);
    chk("t1_neg", last_neg, 2);

    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    repeat (5) drive(1, 7, 0, 0);
    drive(1, 7, 1, 0);
    chk("t2_sad", last_sad, 10);
    drive(1, 7, 0, 0);
    send(7, 1); send(7, 1); send(7, 1);
    drive(0, 0, 1, 0);
    chk("t2_next_sad", last_sad, 28);

    send(10, 1); repeat (3) drive(0, 0, 1, 0);
    send(-10, 1); drive(0, 0, 1, 0);
    send(1, 1); send(1, 1);
    drive(0, 0, 1, 0);
    chk("t3_sad", last_sad, 22);
    chk("t3_neg", last_neg, 1);

    send(20, 1); send(-20, 1);
    drive(1, 50, 1, 1);
    repeat (4) send(1, 1);
    drive(0, 0, 1, 0);
    chk("t4_sad", last_sad, 4);
    chk("t4_neg", last_neg, 0);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    drive(0, 0, 0, 1);
    chk("t4_flush_done", int'(out_valid), 0);
    chk("t4_no_emit", last_sad, 4);

    send(9, 1); send(9, 1);
    reset_mid_cycle();
    repeat (4) send(2, 1);
    drive(0, 0, 1, 0);
    chk("t5_sad", last_sad, 8);

    repeat (4) send(-128, 1);
    drive(0, 0, 1, 0);
    chk("t6_sad", last_sad, 512);
    chk("t6_neg", last_neg, 4);

    v1 = 1; d1 = 8'hFF; r1 = 0;
    @(posedge Clk); #1 v1 = 0;
    chk("c1_out_valid", int'(ov1), 1);
    chk("c1_sad", int'(sad1), 1);
    chk("c1_neg", int'(neg1), 1);
    chk("c1_in_ready", int'(rdy1), 0);
    r1 = 1;
    @(posedge Clk); #1;
    chk("c1_emit_valid", int'(ov1), 0);
    chk("c1_rearm", int'(rdy1), 1);
    v1 = 1; d1 = 8'h80;
    @(posedge Clk); #1 v1 = 0;
    chk("c1_min_sad", int'(sad1), 128);
    chk("c1_min_valid", int'(ov1), 1);
    @(posedge Clk); #1;
    chk("c1_min_emit", int'(ov1), 0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) reset_mid_cycle();
      drive(int'($urandom_range(0, 9) < 7), rand_diff(), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 31) == 0));
    end
    repeat (5) drive(0, 0, 1, 0);
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
